vga_gen2: RTL and testbench
===========================

Name: vga_gen2

Overview:
- Parametrised successor to the miniatom VGA output generator.
- Timing, sync polarity, memory read latency, character height and line replication are all parameters.
- Supports three pixel modes (text, 1 bpp, 2 bpp), a frame-latched scroll base address and a fixed-latency aligned output pipeline.
- Sits between video RAM (synchronous read port) and the board VGA pins.

Parameters:
H_VIS, 512, visible clocks per line
H_FP, 12, horizontal front porch clocks
H_SYNC, 68, hsync pulse clocks
H_BP, 80, horizontal back porch clocks
V_VIS, 768, visible lines
V_FP, 3, vertical front porch lines
V_SYNC, 6, vsync pulse lines
V_BP, 29, vertical back porch lines
HS_POL, 0, hsync active level
VS_POL, 0, vsync active level
ADDR_W, 13, video RAM address width
CHAR_H, 12, text rows per character cell
LINE_REP, 4, scanlines per graphics line
RD_LAT, 1, clocks from rd_en to valid rd_data (1..4)

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-low reset
mode  in  2  00 text, 01 1bpp, 10 2bpp, 11 reserved (treated as 1bpp)
base  in  ADDR_W  frame start address (scroll)
palette  in  24  four 6-bit colours, entry n at [6n+5:6n]
rd_en  out  1  video RAM read strobe
rd_addr  out  ADDR_W  video RAM address
rd_data  in  8  read data, valid RD_LAT clocks after rd_en
rgb  out  6  pixel colour, 0 outside the active area
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
de  out  1  active-area flag, aligned with rgb
frame_start  out  1  one-clock pulse, aligned with the vsync leading edge

Behaviour:
Reset (reset=0, asynchronous):
- Counters, rgb, de, rd_en, rd_addr and frame_start all clear to 0.
- hsync is driven to ~HS_POL and vsync to ~VS_POL.
- The mode and base shadows load 01 and 0.

Counters:
- hcnt runs 0..H_TOT-1, where H_TOT = H_VIS+H_FP+H_SYNC+H_BP.
- vcnt increments when hcnt wraps and runs 0..V_TOT-1.
- Active area: hcnt<H_VIS and vcnt<V_VIS.
- hsync is active for hcnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC). vsync follows the same rule on vcnt.

Frame latch:
- At the first clock of the vsync pulse (vcnt=V_VIS+V_FP, hcnt=0), the mode and base inputs are copied into shadows.
- frame_start pulses at that same clock.
- Mid-frame changes to mode or base have no effect until the next latch.

Fetch:
- Text and 1bpp modes: one byte per 8 clocks (8 pixels). 2bpp mode: one byte per 4 clocks.
- rd_en is high for one clock at hcnt%8==0 (text, 1bpp) or hcnt%4==0 (2bpp), inside the active area only.
- col counts fetches from 0 within a line; BPL = H_VIS/8 or H_VIS/4.
- Graphics address: base + (vcnt/LINE_REP)*BPL + col.
- Text address: base + (vcnt/CHAR_H)*(H_VIS/8) + col.
- All address arithmetic is truncated modulo 2^ADDR_W. Wrap-around is legal and silent.
- Implementation uses incremental row/line counters; no divide.

Pixel path:
- Text mode:
  - Glyph comes from charGen, addressed {rd_data[5:0], char_row}, with char_row = vcnt mod CHAR_H.
  - rd_data[7]=1 inverts the glyph.
  - Glyph bit 1 selects palette entry 1, bit 0 selects entry 0.
  - Rows with char_row ≥ 12 render blank.
- 1bpp: each bit, MSB first, selects palette entry 0 or 1.
- 2bpp: each bit pair, [7:6] first, selects palette entry 0..3.
- The shift register loads on the clock the fetched byte is valid, then shifts once per clock.

Alignment:
- Total latency from counter to rgb is P = RD_LAT+2 clocks.
- hsync, vsync, de and frame_start are each delayed through a P-stage pipeline, so all outputs stay mutually aligned for any RD_LAT.
- rgb is forced to 0 whenever the delayed de is 0.

Corner cases:
- Last fetch of a line: no rd_en beyond the active area.
- Mode 11 renders as 1bpp.
- Reset mid-frame: the frame restarts at hcnt=vcnt=0 after release, with no partial outputs.

Test Plan:
- Default parameters, run 2 frames:
  - hsync low for exactly 68 clocks, period 672 clocks.
  - vsync low for 6 lines, period 806 lines.
  - frame_start pulses once per 541632 clocks.
- mode=01, base=0x0100, line 0:
  - rd_en pulses every 8 clocks, 64 pulses per line.
  - rd_addr 0x0100..0x013F.
  - Lines 0..3 repeat those addresses; line 4 starts at 0x0140.
- mode=10, rd_data=0x1B (00_01_10_11), palette={0x3F,0x30,0x0C,0x03}:
  - rgb shows four pixels 0x03, 0x0C, 0x30, 0x3F in that order.
  - First pixel at hcnt=P.
- RD_LAT=3:
  - The first visible pixel appears on the same clock de rises.
  - The hsync edge stays 524+P clocks after line start.
- base=0x1FF0, ADDR_W=13:
  - Addresses wrap to 0x0000 after 0x1FFF with no glitch on rd_en.
- Change mode from 01 to 00 at line 100:
  - Fetch cadence and rendering stay in 1bpp until frame_start.
  - From the next frame, text addressing applies.

Source files
------------

// File: rtl/vga_gen2.sv
// vga_gen2: parametrised VGA timing, video RAM fetch and pixel serialiser.
// Sync/de/frame_start ride a P = RD_LAT+2 stage pipeline so they line up with rgb.
module vga_gen2 #(
  parameter int   H_VIS    = 512,
  parameter int   H_FP     = 12,
  parameter int   H_SYNC   = 68,
  parameter int   H_BP     = 80,
  parameter int   V_VIS    = 768,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 29,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   ADDR_W   = 13,
  parameter int   CHAR_H   = 12,
  parameter int   LINE_REP = 4,
  parameter int   RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base,
  input  logic [23:0]       palette,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [5:0]        rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_start
);

  localparam int H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int P       = RD_LAT + 2;
  localparam int HW      = $clog2(H_TOT);
  localparam int VW      = $clog2(V_TOT);
  localparam int SUB_MAX = (CHAR_H > LINE_REP) ? CHAR_H : LINE_REP;
  localparam int SW      = $clog2(SUB_MAX + 1);

  logic [HW-1:0]     hcnt;
  logic [VW-1:0]     vcnt;
  logic              h_last, v_last, active, hs_act, vs_act, latch, fetch;
  logic [1:0]        mode_sh;
  logic [ADDR_W-1:0] base_sh, row_base, col, stride;
  logic [SW-1:0]     sub, sub_lim;
  logic              text_m, gfx2;
  logic [RD_LAT-1:0] ld_sr;
  logic              load;
  logic [7:0]        shreg, ld_byte, src, shreg_nxt;
  logic [1:0]        idx;
  logic [5:0]        pix;
  logic [P-1:0]      de_p, hs_p, vs_p, fs_p;

  // Stand-in character generator: 64 codes x 16 rows, addressed {code, row}.
  function automatic logic [7:0] char_gen(input logic [5:0] code, input logic [3:0] row);
    char_gen = {code, 2'b00} ^ {4'h0, row};
  endfunction

  assign h_last = (32'(hcnt) == H_TOT - 1);
  assign v_last = (32'(vcnt) == V_TOT - 1);
  assign active = (32'(hcnt) < H_VIS) && (32'(vcnt) < V_VIS);
  assign hs_act = (32'(hcnt) >= H_VIS + H_FP) && (32'(hcnt) < H_VIS + H_FP + H_SYNC);
  assign vs_act = (32'(vcnt) >= V_VIS + V_FP) && (32'(vcnt) < V_VIS + V_FP + V_SYNC);
  assign latch  = (32'(vcnt) == V_VIS + V_FP) && (hcnt == '0);

  // Mode 11 falls into the 1bpp path: only 00 is text and only 10 is 2bpp.
  assign text_m  = (mode_sh == 2'b00);
  assign gfx2    = (mode_sh == 2'b10);
  assign fetch   = active && (gfx2 ? (hcnt[1:0] == 2'b00) : (hcnt[2:0] == 3'b000));
  assign stride  = gfx2 ? ADDR_W'(H_VIS / 4) : ADDR_W'(H_VIS / 8);
  assign sub_lim = text_m ? SW'(CHAR_H - 1) : SW'(LINE_REP - 1);
  assign load    = ld_sr[RD_LAT-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= v_last ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_sh <= 2'b01;
      base_sh <= '0;
    end else if (latch) begin
      mode_sh <= mode;
      base_sh <= base;
    end
  end

  // row_base tracks base + row*stride incrementally; sub counts scanlines within a row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      col      <= '0;
      sub      <= '0;
      row_base <= '0;
    end else begin
      rd_en <= fetch;
      if (fetch) begin
        rd_addr <= row_base + col;
        col     <= col + 1'b1;
      end
      if (h_last) begin
        col <= '0;
        if (v_last) begin
          sub      <= '0;
          row_base <= base_sh;
        end else if (sub == sub_lim) begin
          sub      <= '0;
          row_base <= row_base + stride;
        end else begin
          sub <= sub + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_sr <= '0;
      de_p  <= '0;
      fs_p  <= '0;
      hs_p  <= {P{~HS_POL}};
      vs_p  <= {P{~VS_POL}};
    end else begin
      ld_sr <= RD_LAT'({ld_sr, rd_en});
      de_p  <= P'({de_p, active});
      fs_p  <= P'({fs_p, latch});
      hs_p  <= P'({hs_p, (hs_act ? HS_POL : ~HS_POL)});
      vs_p  <= P'({vs_p, (vs_act ? VS_POL : ~VS_POL)});
    end
  end

  // The first pixel of a byte comes straight from rd_data so rgb lands at exactly P.
  always_comb begin
    ld_byte = rd_data;
    if (text_m) begin
      ld_byte = char_gen(rd_data[5:0], 4'(sub)) ^ {8{rd_data[7]}};
      if (32'(sub) >= 12) ld_byte = 8'h00;
    end
    src       = load ? ld_byte : shreg;
    idx       = gfx2 ? src[7:6] : {1'b0, src[7]};
    shreg_nxt = gfx2 ? {src[5:0], 2'b00} : {src[6:0], 1'b0};
    case (idx)
      2'd0:    pix = palette[5:0];
      2'd1:    pix = palette[11:6];
      2'd2:    pix = palette[17:12];
      default: pix = palette[23:18];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      rgb   <= '0;
    end else begin
      shreg <= shreg_nxt;
      rgb   <= de_p[P-2] ? pix : 6'h00;
    end
  end

  assign de          = de_p[P-1];
  assign hsync       = hs_p[P-1];
  assign vsync       = vs_p[P-1];
  assign frame_start = fs_p[P-1];

endmodule

// File: tb/tb_vga_gen2.sv
// Scoreboard bench for vga_gen2 on a reduced raster: expected fetch addresses and
// pixels are queued per frame; monitors pop them on rd_en / de.
module tb_vga_gen2;

  localparam int H_VIS = 32, H_FP = 2, H_SYNC = 4, H_BP = 2;
  localparam int V_VIS = 28, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;   // 40
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;   // 32
  localparam int FRAME = H_TOT * V_TOT;                  // 1280
  localparam int ADDR_W = 13, CHAR_H = 14, LINE_REP = 4, RD_LAT = 3;
  localparam int P = RD_LAT + 2;
  localparam int NF = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] base;
  logic [23:0]       palette;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [5:0]        rgb;
  logic              hsync, vsync, de, frame_start;

  vga_gen2 #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b0), .VS_POL(1'b0), .ADDR_W(ADDR_W), .CHAR_H(CHAR_H),
    .LINE_REP(LINE_REP), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .base(base), .palette(palette),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rgb(rgb),
    .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Video RAM with RD_LAT clocks of read latency.
  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] ra_p [RD_LAT];
  always @(posedge clk) begin
    ra_p[0] <= rd_addr;
    for (int i = 1; i < RD_LAT; i++) ra_p[i] <= ra_p[i-1];
  end
  assign rd_data = mem[ra_p[RD_LAT-1]];

  // Frame table: frame 0 runs on the reset shadows (01, base 0).
  logic [1:0]        m_tab [NF] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
  logic [ADDR_W-1:0] b_tab [NF] = '{13'h0000, 13'h0100, 13'h0200, 13'h1FFE, 13'h0300, 13'h1FF8};
  logic [23:0] pal_a = {6'h3F, 6'h30, 6'h0C, 6'h03};
  logic [23:0] pal_b = {6'h11, 6'h22, 6'h2A, 6'h15};

  logic [ADDR_W-1:0] exp_addr [$];
  logic [5:0]        exp_pix  [$];
  int checks = 0;
  int errors = 0;
  logic mon_on = 1'b0;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic push_frame(input logic [1:0] m, input logic [ADDR_W-1:0] b, input logic [23:0] pal);
    int per, bpl, row, r;
    logic [ADDR_W-1:0] a;
    logic [7:0] byt, g, tmp;
    logic [1:0] ix;
    per = (m == 2'b10) ? 4 : 8;
    bpl = H_VIS / per;
    for (int v = 0; v < V_VIS; v++) begin
      row = (m == 2'b00) ? v / CHAR_H : v / LINE_REP;
      r   = v % CHAR_H;
      for (int c = 0; c < bpl; c++) begin
        a = ADDR_W'(int'(b) + row * bpl + c);
        exp_addr.push_back(a);
        byt = mem[a];
        g = 8'h00;
        if (r < 12) g = ({byt[5:0], 2'b00} ^ 8'(r)) ^ {8{byt[7]}};
        for (int k = 0; k < per; k++) begin
          if (m == 2'b00) begin
            tmp = g << k;
            ix  = {1'b0, tmp[7]};
          end else if (m == 2'b10) begin
            tmp = byt << (2 * k);
            ix  = tmp[7:6];
          end else begin
            tmp = byt << k;
            ix  = {1'b0, tmp[7]};
          end
          exp_pix.push_back(pal[int'(ix)*6 +: 6]);
        end
      end
    end
  endtask

  // Data monitor: rd_en and de act as the DUT's output valids.
  always @(negedge clk) begin
    if (mon_on && reset) begin
      if (rd_en) begin
        if (exp_addr.size() == 0) check("addr_underflow", 0, 1);
        else check("rd_addr", rd_addr, exp_addr.pop_front());
      end
      if (de) begin
        if (exp_pix.size() == 0) check("pix_underflow", 0, 1);
        else check("rgb", rgb, exp_pix.pop_front());
      end else begin
        check("rgb_blank", rgb, 0);
      end
    end
  end

  // Sync monitor: widths, periods, and mutual alignment.
  int cyc = 0, hs_fall = -1, vs_fall = -1, fs_last = -1, de_rise = -1;
  logic hs_prev = 1'b1, vs_prev = 1'b1, de_prev = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (mon_on && reset) begin
      if (!de_prev && de) de_rise = cyc;
      if (hs_prev && !hsync) begin
        if (hs_fall >= 0) check("hsync_period", cyc - hs_fall, H_TOT);
        if (de_rise >= 0) check("de_to_hsync", cyc - de_rise, H_VIS + H_FP);
        hs_fall = cyc;
        de_rise = -1;
      end
      if (!hs_prev && hsync && hs_fall >= 0) check("hsync_width", cyc - hs_fall, H_SYNC);
      if (vs_prev && !vsync) begin
        if (vs_fall >= 0) check("vsync_period", cyc - vs_fall, FRAME);
        vs_fall = cyc;
      end
      if (!vs_prev && vsync && vs_fall >= 0) check("vsync_width", cyc - vs_fall, V_SYNC * H_TOT);
      if (frame_start) begin
        check("fs_on_vsync_edge", {vs_prev, vsync}, 2'b10);
        if (fs_last >= 0) check("fs_period", cyc - fs_last, FRAME);
        fs_last = cyc;
      end
    end
    hs_prev = hsync;
    vs_prev = vsync;
    de_prev = de;
  end

  task automatic measure_start(input string tag);
    int rd_first, de_first;
    rd_first = -1;
    de_first = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (rd_en && rd_first < 0) rd_first = i;
      if (de && de_first < 0) de_first = i;
    end
    check({tag, "_rd_en_first"}, rd_first, 1);
    check({tag, "_de_first"}, de_first, P);
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (frame_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 8'((a * 29) ^ (a >> 4));
    mem[13'h0200] = 8'h1B;
    reset   = 1'b0;
    mode    = m_tab[1];
    base    = b_tab[1];
    palette = pal_a;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb", rgb, 0);
    check("rst_de", de, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);

    @(negedge clk);
    push_frame(2'b01, '0, pal_a);
    mon_on = 1'b1;
    reset  = 1'b1;
    measure_start("start");

    for (int k = 1; k < NF; k++) begin
      wait_fs(ok);
      if (!ok) begin
        check("frame_start_timeout", 0, 1);
        break;
      end
      palette = (k == 4 || k == 3) ? pal_b : pal_a;
      push_frame(m_tab[k], b_tab[k], palette);
      if (k < NF - 1) begin
        repeat (12 * H_TOT) @(posedge clk);
        mode = m_tab[k+1];
        base = b_tab[k+1];
      end
    end

    for (int i = 0; i < 2 * FRAME && exp_pix.size() != 0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    check("pix_queue_drained", exp_pix.size(), 0);
    check("addr_queue_drained", exp_addr.size(), 0);
    mon_on = 1'b0;

    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (de) begin
        ok = 1'b1;
        break;
      end
    end
    check("midframe_de_seen", ok, 1);
    reset = 1'b0;
    #1;
    check("midrst_de", de, 0);
    check("midrst_rgb", rgb, 0);
    check("midrst_rd_en", rd_en, 0);
    check("midrst_hsync", hsync, 1);
    @(negedge clk);
    reset = 1'b1;
    measure_start("restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
